// File: rtl/mos6502_decode_pkg.sv
// Shared types and the opcode lookup table for the 6502 streaming decoder.
package mos6502_decode_pkg;

   typedef enum logic [5:0] {
      MnAdc, MnAnd, MnAsl, MnBcc, MnBcs, MnBeq, MnBit, MnBmi, MnBne, MnBpl, MnBrk, MnBvc,
      MnBvs, MnClc, MnCld, MnCli, MnClv, MnCmp, MnCpx, MnCpy, MnDec, MnDex, MnDey, MnEor,
      MnInc, MnInx, MnIny, MnJmp, MnJsr, MnLda, MnLdx, MnLdy, MnLsr, MnNop, MnOra, MnPha,
      MnPhp, MnPla, MnPlp, MnRol, MnRor, MnRti, MnRts, MnSbc, MnSec, MnSed, MnSei, MnSta,
      MnStx, MnSty, MnTax, MnTay, MnTsx, MnTxa, MnTxs, MnTya
   } mnem_e;

   typedef enum logic [3:0] {
      MdAcc, MdImpl, MdImm, MdZpg, MdZpgX, MdZpgY, MdAbs, MdAbsX, MdAbsY, MdInd, MdXind,
      MdIndY, MdRel
   } mode_e;

   typedef struct packed {
      mnem_e      mnem;
      mode_e      mode;
      logic [1:0] len;
      logic       illegal;
   } dec_t;

   typedef struct packed {
      mnem_e       mnem;
      mode_e       mode;
      logic [15:0] operand;
      logic [1:0]  len;
      logic        illegal;
   } rec_t;

   // Operand byte count implied by the addressing mode.
   function automatic logic [1:0] mode_len(input mode_e md);
      logic [1:0] n;
      case (md)
         MdAcc, MdImpl:                n = 2'd0;
         MdAbs, MdAbsX, MdAbsY, MdInd: n = 2'd2;
         default:                      n = 2'd1;
      endcase
      return n;
   endfunction

   function automatic dec_t mk(input mnem_e mn, input mode_e md);
      return '{mnem: mn, mode: md, len: mode_len(md), illegal: 1'b0};
   endfunction

   // Undocumented opcodes decode as a zero-length NOP flagged illegal.
   function automatic dec_t decode_opcode(input logic [7:0] op);
      dec_t d;
      case (op)
         8'h69: d = mk(MnAdc, MdImm);  8'h65: d = mk(MnAdc, MdZpg);  8'h75: d = mk(MnAdc, MdZpgX);
         8'h6D: d = mk(MnAdc, MdAbs);  8'h7D: d = mk(MnAdc, MdAbsX); 8'h79: d = mk(MnAdc, MdAbsY);
         8'h61: d = mk(MnAdc, MdXind); 8'h71: d = mk(MnAdc, MdIndY);
         8'h29: d = mk(MnAnd, MdImm);  8'h25: d = mk(MnAnd, MdZpg);  8'h35: d = mk(MnAnd, MdZpgX);
         8'h2D: d = mk(MnAnd, MdAbs);  8'h3D: d = mk(MnAnd, MdAbsX); 8'h39: d = mk(MnAnd, MdAbsY);
         8'h21: d = mk(MnAnd, MdXind); 8'h31: d = mk(MnAnd, MdIndY);
         8'h0A: d = mk(MnAsl, MdAcc);  8'h06: d = mk(MnAsl, MdZpg);  8'h16: d = mk(MnAsl, MdZpgX);
         8'h0E: d = mk(MnAsl, MdAbs);  8'h1E: d = mk(MnAsl, MdAbsX);
         8'h90: d = mk(MnBcc, MdRel);  8'hB0: d = mk(MnBcs, MdRel);  8'hF0: d = mk(MnBeq, MdRel);
         8'h30: d = mk(MnBmi, MdRel);  8'hD0: d = mk(MnBne, MdRel);  8'h10: d = mk(MnBpl, MdRel);
         8'h50: d = mk(MnBvc, MdRel);  8'h70: d = mk(MnBvs, MdRel);
         8'h24: d = mk(MnBit, MdZpg);  8'h2C: d = mk(MnBit, MdAbs);  8'h00: d = mk(MnBrk, MdImpl);
         8'h18: d = mk(MnClc, MdImpl); 8'hD8: d = mk(MnCld, MdImpl); 8'h58: d = mk(MnCli, MdImpl);
         8'hB8: d = mk(MnClv, MdImpl);
         8'hC9: d = mk(MnCmp, MdImm);  8'hC5: d = mk(MnCmp, MdZpg);  8'hD5: d = mk(MnCmp, MdZpgX);
         8'hCD: d = mk(MnCmp, MdAbs);  8'hDD: d = mk(MnCmp, MdAbsX); 8'hD9: d = mk(MnCmp, MdAbsY);
         8'hC1: d = mk(MnCmp, MdXind); 8'hD1: d = mk(MnCmp, MdIndY);
         8'hE0: d = mk(MnCpx, MdImm);  8'hE4: d = mk(MnCpx, MdZpg);  8'hEC: d = mk(MnCpx, MdAbs);
         8'hC0: d = mk(MnCpy, MdImm);  8'hC4: d = mk(MnCpy, MdZpg);  8'hCC: d = mk(MnCpy, MdAbs);
         8'hC6: d = mk(MnDec, MdZpg);  8'hD6: d = mk(MnDec, MdZpgX); 8'hCE: d = mk(MnDec, MdAbs);
         8'hDE: d = mk(MnDec, MdAbsX); 8'hCA: d = mk(MnDex, MdImpl); 8'h88: d = mk(MnDey, MdImpl);
         8'h49: d = mk(MnEor, MdImm);  8'h45: d = mk(MnEor, MdZpg);  8'h55: d = mk(MnEor, MdZpgX);
         8'h4D: d = mk(MnEor, MdAbs);  8'h5D: d = mk(MnEor, MdAbsX); 8'h59: d = mk(MnEor, MdAbsY);
         8'h41: d = mk(MnEor, MdXind); 8'h51: d = mk(MnEor, MdIndY);
         8'hE6: d = mk(MnInc, MdZpg);  8'hF6: d = mk(MnInc, MdZpgX); 8'hEE: d = mk(MnInc, MdAbs);
         8'hFE: d = mk(MnInc, MdAbsX); 8'hE8: d = mk(MnInx, MdImpl); 8'hC8: d = mk(MnIny, MdImpl);
         8'h4C: d = mk(MnJmp, MdAbs);  8'h6C: d = mk(MnJmp, MdInd);  8'h20: d = mk(MnJsr, MdAbs);
         8'hA9: d = mk(MnLda, MdImm);  8'hA5: d = mk(MnLda, MdZpg);  8'hB5: d = mk(MnLda, MdZpgX);
         8'hAD: d = mk(MnLda, MdAbs);  8'hBD: d = mk(MnLda, MdAbsX); 8'hB9: d = mk(MnLda, MdAbsY);
         8'hA1: d = mk(MnLda, MdXind); 8'hB1: d = mk(MnLda, MdIndY);
         8'hA2: d = mk(MnLdx, MdImm);  8'hA6: d = mk(MnLdx, MdZpg);  8'hB6: d = mk(MnLdx, MdZpgY);
         8'hAE: d = mk(MnLdx, MdAbs);  8'hBE: d = mk(MnLdx, MdAbsY);
         8'hA0: d = mk(MnLdy, MdImm);  8'hA4: d = mk(MnLdy, MdZpg);  8'hB4: d = mk(MnLdy, MdZpgX);
         8'hAC: d = mk(MnLdy, MdAbs);  8'hBC: d = mk(MnLdy, MdAbsX);
         8'h4A: d = mk(MnLsr, MdAcc);  8'h46: d = mk(MnLsr, MdZpg);  8'h56: d = mk(MnLsr, MdZpgX);
         8'h4E: d = mk(MnLsr, MdAbs);  8'h5E: d = mk(MnLsr, MdAbsX); 8'hEA: d = mk(MnNop, MdImpl);
         8'h09: d = mk(MnOra, MdImm);  8'h05: d = mk(MnOra, MdZpg);  8'h15: d = mk(MnOra, MdZpgX);
         8'h0D: d = mk(MnOra, MdAbs);  8'h1D: d = mk(MnOra, MdAbsX); 8'h19: d = mk(MnOra, MdAbsY);
         8'h01: d = mk(MnOra, MdXind); 8'h11: d = mk(MnOra, MdIndY);
         8'h48: d = mk(MnPha, MdImpl); 8'h08: d = mk(MnPhp, MdImpl); 8'h68: d = mk(MnPla, MdImpl);
         8'h28: d = mk(MnPlp, MdImpl);
         8'h2A: d = mk(MnRol, MdAcc);  8'h26: d = mk(MnRol, MdZpg);  8'h36: d = mk(MnRol, MdZpgX);
         8'h2E: d = mk(MnRol, MdAbs);  8'h3E: d = mk(MnRol, MdAbsX);
         8'h6A: d = mk(MnRor, MdAcc);  8'h66: d = mk(MnRor, MdZpg);  8'h76: d = mk(MnRor, MdZpgX);
         8'h6E: d = mk(MnRor, MdAbs);  8'h7E: d = mk(MnRor, MdAbsX);
         8'h40: d = mk(MnRti, MdImpl); 8'h60: d = mk(MnRts, MdImpl);
         8'hE9: d = mk(MnSbc, MdImm);  8'hE5: d = mk(MnSbc, MdZpg);  8'hF5: d = mk(MnSbc, MdZpgX);
         8'hED: d = mk(MnSbc, MdAbs);  8'hFD: d = mk(MnSbc, MdAbsX); 8'hF9: d = mk(MnSbc, MdAbsY);
         8'hE1: d = mk(MnSbc, MdXind); 8'hF1: d = mk(MnSbc, MdIndY);
         8'h38: d = mk(MnSec, MdImpl); 8'hF8: d = mk(MnSed, MdImpl); 8'h78: d = mk(MnSei, MdImpl);
         8'h85: d = mk(MnSta, MdZpg);  8'h95: d = mk(MnSta, MdZpgX); 8'h8D: d = mk(MnSta, MdAbs);
         8'h9D: d = mk(MnSta, MdAbsX); 8'h99: d = mk(MnSta, MdAbsY); 8'h81: d = mk(MnSta, MdXind);
         8'h91: d = mk(MnSta, MdIndY);
         8'h86: d = mk(MnStx, MdZpg);  8'h96: d = mk(MnStx, MdZpgY); 8'h8E: d = mk(MnStx, MdAbs);
         8'h84: d = mk(MnSty, MdZpg);  8'h94: d = mk(MnSty, MdZpgX); 8'h8C: d = mk(MnSty, MdAbs);
         8'hAA: d = mk(MnTax, MdImpl); 8'hA8: d = mk(MnTay, MdImpl); 8'hBA: d = mk(MnTsx, MdImpl);
         8'h8A: d = mk(MnTxa, MdImpl); 8'h9A: d = mk(MnTxs, MdImpl); 8'h98: d = mk(MnTya, MdImpl);
         default: d = '{mnem: MnNop, mode: MdImpl, len: 2'd0, illegal: 1'b1};
      endcase
      return d;
   endfunction

endpackage

// File: rtl/decoded_rec_fifo.sv
// Small synchronous FIFO of decoded records; head reads as zero while empty.
module decoded_rec_fifo
   import mos6502_decode_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  logic push,
   input  rec_t push_data,
   input  logic pop,
   output rec_t head,
   output logic full,
   output logic empty
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

   if (FIFO_DEPTH == 0 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two and at least 1");
   end

   rec_t            mem [FIFO_DEPTH];
   logic [PtrW-1:0] wptr, rptr;
   logic [CntW-1:0] count;
   logic            do_push, do_pop;

   assign full    = (count == CntW'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = empty ? '0 : mem[rptr];

   // Pointer and occupancy bookkeeping; flush empties the queue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= (wptr == PtrW'(FIFO_DEPTH - 1)) ? '0 : wptr + PtrW'(1);
         if (do_pop)  rptr <= (rptr == PtrW'(FIFO_DEPTH - 1)) ? '0 : rptr + PtrW'(1);
         if (do_push && !do_pop)      count <= count + CntW'(1);
         else if (do_pop && !do_push) count <= count - CntW'(1);
      end
   end

   // Storage needs no reset: head is masked while empty.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wptr] <= push_data;
   end

endmodule

// File: rtl/mos6502_decode_stream.sv
// Collects opcode + operand bytes into one decoded record per 6502 instruction.
module mos6502_decode_stream
   import mos6502_decode_pkg::*;
#(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned MNEM_W     = 6,
   parameter int unsigned MODE_W     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_byte,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [MNEM_W-1:0] out_mnem,
   output logic [MODE_W-1:0] out_mode,
   output logic [15:0]       out_operand,
   output logic [1:0]        out_len,
   output logic              out_illegal
);

   if (DATA_W != 8) begin : g_bad_data_w
      $error("DATA_W must be 8");
   end
   if (MNEM_W < $bits(mnem_e) || MODE_W < $bits(mode_e)) begin : g_bad_code_w
      $error("MNEM_W/MODE_W too narrow for the package enums");
   end

   typedef enum logic [1:0] {StOpc, StLo, StHi} state_e;

   state_e     state_q, state_d;
   dec_t       dec_q, dec_now;
   logic [7:0] lo_q;
   logic       accept, push, fifo_full, fifo_empty;
   rec_t       push_rec, head;

   assign dec_now  = decode_opcode(in_byte[7:0]);
   assign in_ready = !fifo_full;
   assign accept   = in_valid && in_ready && !flush;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StOpc;
      else     state_q <= state_d;
   end

   // Next-state: walk opcode -> lo -> hi as far as the opcode length requires.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = StOpc;
      end else if (accept) begin
         unique case (state_q)
            StOpc:   if (dec_now.len != 2'd0) state_d = StLo;
            StLo:    state_d = (dec_q.len == 2'd2) ? StHi : StOpc;
            StHi:    state_d = StOpc;
            default: state_d = StOpc;
         endcase
      end
   end

   // Outputs: build the record on the cycle its final byte is accepted.
   always_comb begin
      push     = 1'b0;
      push_rec = '0;
      if (accept) begin
         unique case (state_q)
            StOpc: begin
               push     = (dec_now.len == 2'd0);
               push_rec = '{mnem: dec_now.mnem, mode: dec_now.mode, operand: 16'h0000,
                            len: dec_now.len, illegal: dec_now.illegal};
            end
            StLo: begin
               push     = (dec_q.len == 2'd1);
               push_rec = '{mnem: dec_q.mnem, mode: dec_q.mode, operand: {8'h00, in_byte[7:0]},
                            len: dec_q.len, illegal: dec_q.illegal};
            end
            StHi: begin
               push     = 1'b1;
               push_rec = '{mnem: dec_q.mnem, mode: dec_q.mode, operand: {in_byte[7:0], lo_q},
                            len: dec_q.len, illegal: dec_q.illegal};
            end
            default: push = 1'b0;
         endcase
      end
   end

   // Partial-instruction holding registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dec_q <= '0;
         lo_q  <= '0;
      end else if (flush) begin
         dec_q <= '0;
         lo_q  <= '0;
      end else if (accept) begin
         if (state_q == StOpc) dec_q <= dec_now;
         if (state_q == StLo)  lo_q  <= in_byte[7:0];
      end
   end

   decoded_rec_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (push),
      .push_data (push_rec),
      .pop       (out_ready),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign out_valid   = !fifo_empty;
   assign out_mnem    = MNEM_W'(head.mnem);
   assign out_mode    = MODE_W'(head.mode);
   assign out_operand = head.operand;
   assign out_len     = head.len;
   assign out_illegal = head.illegal;

endmodule

// File: tb/tb_mos6502_decode_stream.sv
// Scoreboard bench for the streaming 6502 decoder.
module tb_mos6502_decode_stream;
   import mos6502_decode_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_byte = 8'h00;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [5:0]  out_mnem;
   logic [3:0]  out_mode;
   logic [15:0] out_operand;
   logic [1:0]  out_len;
   logic        out_illegal;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   rec_t exp_q[$];
   int   pop_cyc[$];

   mos6502_decode_stream #(
      .DATA_W     (8),
      .FIFO_DEPTH (2),
      .MNEM_W     (6),
      .MODE_W     (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_byte     (in_byte),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_mnem    (out_mnem),
      .out_mode    (out_mode),
      .out_operand (out_operand),
      .out_len     (out_len),
      .out_illegal (out_illegal)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic rec_t r(input mnem_e m, input mode_e md, input logic [15:0] op,
                              input logic [1:0] len, input logic ill);
      return '{mnem: m, mode: md, operand: op, len: len, illegal: ill};
   endfunction

   // Scoreboard: every record the consumer takes must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         rec_t e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_record: got mnem=%0d mode=%0d op=%h len=%0d ill=%0d, none expected",
                     out_mnem, out_mode, out_operand, out_len, out_illegal);
         end else begin
            e = exp_q.pop_front();
            if ({out_mnem, out_mode, out_operand, out_len, out_illegal} !== e) begin
               errors++;
               $display("FAIL record: got mnem=%0d mode=%0d op=%h len=%0d ill=%0d, want mnem=%0d mode=%0d op=%h len=%0d ill=%0d",
                        out_mnem, out_mode, out_operand, out_len, out_illegal,
                        e.mnem, e.mode, e.operand, e.len, e.illegal);
            end
         end
         pop_cyc.push_back(cyc);
      end
   end

   // Present one byte and hold it until accepted (leaves in_valid high).
   task automatic send(input logic [7:0] b, output int waited);
      waited = 0;
      in_valid = 1'b1;
      in_byte  = b;
      @(negedge clk);
      while (!in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("FAIL accept_%h: in_ready=%b after %0d cycles, want 1", b, in_ready, waited);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_byte  = 8'h00;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d records still pending, want 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      checks++;
      if ({out_mnem, out_mode, out_operand, out_len, out_illegal} !== 29'h0) begin
         errors++;
         $display("FAIL reset_fields: got %h want 0",
                  {out_mnem, out_mode, out_operand, out_len, out_illegal});
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_load_imm();
      int w;
      out_ready = 1'b1;
      send(8'hA9, w);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL lda_early_valid: got %b want 0", out_valid);
      end
      exp_q.push_back(r(MnLda, MdImm, 16'h0042, 2'd1, 1'b0));
      send(8'h42, w);
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL lda_latency: out_valid=%b one cycle after last byte, want 1", out_valid);
      end
      idle();
      drain("lda");
   endtask

   task automatic test_back_to_back();
      int w, total;
      total = 0;
      pop_cyc.delete();
      exp_q.push_back(r(MnSta, MdAbs, 16'h2000, 2'd2, 1'b0));
      exp_q.push_back(r(MnInx, MdImpl, 16'h0000, 2'd0, 1'b0));
      send(8'h8D, w); total += w;
      send(8'h00, w); total += w;
      send(8'h20, w); total += w;
      send(8'hE8, w); total += w;
      idle();
      drain("b2b");
      checks++;
      if (total != 0) begin
         errors++;
         $display("FAIL b2b_stalls: got %0d stall cycles want 0", total);
      end
      checks++;
      if (pop_cyc.size() != 2 || pop_cyc[1] - pop_cyc[0] != 1) begin
         errors++;
         $display("FAIL b2b_bubble: got %0d records / gap %0d, want 2 / 1", pop_cyc.size(),
                  (pop_cyc.size() == 2) ? pop_cyc[1] - pop_cyc[0] : -1);
      end
   endtask

   task automatic test_illegal();
      int w;
      exp_q.push_back(r(MnNop, MdImpl, 16'h0000, 2'd0, 1'b1));
      send(8'h02, w);
      checks++;
      if (out_valid !== 1'b1 || out_illegal !== 1'b1) begin
         errors++;
         $display("FAIL illegal_flag: got valid=%b illegal=%b want 1 1", out_valid, out_illegal);
      end
      exp_q.push_back(r(MnLda, MdImm, 16'h0010, 2'd1, 1'b0));
      send(8'hA9, w);
      send(8'h10, w);
      idle();
      drain("illegal");
   endtask

   task automatic test_backpressure();
      int w;
      out_ready = 1'b0;
      exp_q.push_back(r(MnInx, MdImpl, 16'h0000, 2'd0, 1'b0));
      send(8'hE8, w);
      exp_q.push_back(r(MnIny, MdImpl, 16'h0000, 2'd0, 1'b0));
      send(8'hC8, w);
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_full_ready: got %b want 0", in_ready);
      end
      in_valid = 1'b1;
      in_byte  = 8'hCA;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
             {out_mnem, out_mode, out_operand, out_len} !== {MnInx, MdImpl, 16'h0000, 2'd0}) begin
            errors++;
            $display("FAIL bp_hold_%0d: got ready=%b valid=%b mnem=%0d mode=%0d, want 0 1 %0d %0d",
                     i, in_ready, out_valid, out_mnem, out_mode, MnInx, MdImpl);
         end
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      exp_q.push_back(r(MnDex, MdImpl, 16'h0000, 2'd0, 1'b0));
      send(8'hCA, w);
      idle();
      drain("bp");
   endtask

   task automatic test_flush();
      int w;
      out_ready = 1'b1;
      send(8'h4C, w);
      send(8'h34, w);
      in_valid = 1'b1;
      in_byte  = 8'h99;
      flush    = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      idle();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_partial: out_valid=%b want 0", out_valid);
      end
      exp_q.push_back(r(MnInx, MdImpl, 16'h0000, 2'd0, 1'b0));
      send(8'hE8, w);
      idle();
      drain("flush");
      // Buffered record must be discarded too.
      out_ready = 1'b0;
      send(8'hC8, w);
      idle();
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL flush_fill: out_valid=%b want 1", out_valid);
      end
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_mnem !== 6'd0) begin
         errors++;
         $display("FAIL flush_fifo: got valid=%b ready=%b mnem=%0d want 0 1 0",
                  out_valid, in_ready, out_mnem);
      end
      out_ready = 1'b1;
   endtask

   task automatic test_reset_mid();
      int w;
      out_ready = 1'b0;
      send(8'hE8, w);
      send(8'h20, w);
      send(8'h00, w);
      idle();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_mnem !== 6'd0) begin
         errors++;
         $display("FAIL async_reset: got valid=%b mnem=%0d want 0 0", out_valid, out_mnem);
      end
      exp_q.delete();
      #3;
      rst = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      exp_q.push_back(r(MnLda, MdImm, 16'h0005, 2'd1, 1'b0));
      send(8'hA9, w);
      send(8'h05, w);
      idle();
      drain("reset_mid");
   endtask

   initial begin
      test_reset();
      test_load_imm();
      test_back_to_back();
      test_illegal();
      test_backpressure();
      test_flush();
      test_reset_mid();
      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
